// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state codes and default width.
package serial_add_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADD  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// 1-bit full adder: the whole arithmetic datapath of the serial adder.
module full_adder (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);

  assign sum_out   = a_in ^ b_in ^ c_in;
  assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder over a WIDTH-bit operand pair, LSB first.
// Handshake: start_in is sampled only in IDLE; done_out pulses for one cycle while sum_out/carry_out hold the result.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [1:0]       dbg_state_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_full_adder (
    .a_in      (a_sr_q[0]),
    .b_in      (b_sr_q[0]),
    .c_in      (cy_q),
    .sum_out   (fa_sum),
    .carry_out (fa_carry)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          cy_d    = c_in;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        s_sr_d = {fa_sum, s_sr_q[WIDTH-1:1]};
        cy_d   = fa_carry;
        if (cnt_q == LAST_BIT) begin
          // Result includes the bit being summed this very cycle.
          sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_out      = (state_q != ST_IDLE);
  assign done_out      = (state_q == ST_DONE);
  assign sum_out       = sum_q;
  assign carry_out     = cout_q;
  assign dbg_state_out = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): expected {carry,sum} queued at issue, popped on done_out.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic         start_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         carry_out;
  logic [1:0]   dbg_state_out;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int dones  = 0;
  logic [W:0]   exp_q[$];
  logic [W-1:0] prev_sum;
  logic         prev_carry;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_in      (start_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .c_in          (c_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .sum_out       (sum_out),
    .carry_out     (carry_out),
    .dbg_state_out (dbg_state_out)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: pops the scoreboard on every done pulse, checks result stability otherwise.
  always @(negedge clock) begin
    if (reset) begin
      prev_sum   = sum_out;
      prev_carry = carry_out;
    end else if (done_out) begin
      logic [W:0] exp_v;
      dones++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got=%h", {carry_out, sum_out});
      end else begin
        exp_v = exp_q.pop_front();
        if ({carry_out, sum_out} !== exp_v) begin
          errors++;
          $display("FAIL result got=%h exp=%h", {carry_out, sum_out}, exp_v);
        end
      end
      prev_sum   = sum_out;
      prev_carry = carry_out;
    end else begin
      checks++;
      if (sum_out !== prev_sum || carry_out !== prev_carry) begin
        errors++;
        $display("FAIL stable got=%h exp=%h", {carry_out, sum_out}, {prev_carry, prev_sum});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_idle();
    int n = 0;
    while (busy_out && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("idle_timeout", {31'd0, busy_out}, 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    wait_idle();
    a_in     = a;
    b_in     = b;
    c_in     = c;
    start_in = 1'b1;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    pushed++;
    @(posedge clock); #1;
    start_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int busy_cnt;
    int done_idx;
    int last_done;
    int ndone;

    reset    = 1'b1;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    c_in     = 1'b0;
    #1;
    check("rst_busy",  {31'd0, busy_out},  0);
    check("rst_done",  {31'd0, done_out},  0);
    check("rst_sum",   {24'd0, sum_out},   0);
    check("rst_carry", {31'd0, carry_out}, 0);
    check("rst_state", {30'd0, dbg_state_out}, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Latency and busy window for 0x3C + 0x15.
    issue(8'h3C, 8'h15, 1'b0);
    busy_cnt = 1;
    done_idx = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (busy_out) busy_cnt++;
      if (done_out && done_idx < 0) done_idx = k;
    end
    check("lat_done_idx", done_idx, W);
    check("lat_busy_cnt", busy_cnt, W + 1);

    // Carry-out cases.
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    drain();

    // start during ADD and DONE is ignored.
    issue(8'h10, 8'h20, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    a_in = 8'hAA; b_in = 8'h55; start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    for (int n = 0; n < 20 && !done_out; n++) begin
      @(posedge clock); #1;
    end
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("ignored_start_busy", {31'd0, busy_out}, 0);
    check("ignored_start_queue", exp_q.size(), 0);

    // Asynchronous abort in ADD cycle 5.
    issue(8'h7F, 8'h01, 1'b0);
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",  {31'd0, busy_out},  0);
    check("abort_done",  {31'd0, done_out},  0);
    check("abort_sum",   {24'd0, sum_out},   0);
    check("abort_carry", {31'd0, carry_out}, 0);
    exp_q.delete();
    pushed--;
    @(posedge clock); #1;
    reset = 1'b0;
    issue(8'h7F, 8'h01, 1'b0);
    drain();

    // start held high: back-to-back accepts every W+2 cycles with fresh operands.
    wait_idle();
    start_in  = 1'b1;
    last_done = -1;
    ndone     = 0;
    for (int i = 0; i < 40; i++) begin
      a_in = 8'(i * 29 + 3);
      b_in = 8'(i * 83 + 11);
      c_in = 1'(i);
      if (i % (W + 2) == 0) begin
        exp_q.push_back({1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, c_in});
        pushed++;
      end
      @(posedge clock); #1;
      if (done_out) begin
        if (last_done >= 0) check("b2b_spacing", i - last_done, W + 2);
        last_done = i;
        ndone++;
      end
    end
    start_in = 1'b0;
    check("b2b_count", ndone, 4);
    drain();

    // Reference-model random sweep.
    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    drain();
    repeat (3) @(posedge clock);
    #1;
    check("done_count", dones, pushed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
